// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and sizing for serial_tx_shifter; SERIAL_TX_PARITY_EN adds the parity frame bit
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY
  } state_t;

`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_tx_shifter_if.sv
// rtl/serial_tx_shifter_if.sv - load handshake and serial frame signals of serial_tx_shifter
interface serial_tx_shifter_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             sdata;
  logic             sframe;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  sdata,
    input  sframe,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output sdata,
    output sframe,
    output done
  );
endinterface

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load shift register whose end bit drives the serial line
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out
);
  logic [WIDTH-1:0] sr;

  // zero fill means the register is empty (sdata=0) once a full frame has left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= data_in;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        sr <= {sr[WIDTH-2:0], 1'b0};
      end else begin
        sr <= {1'b0, sr[WIDTH-1:1]};
      end
    end
  end

  assign serial_out = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];
endmodule

// File: rtl/serial_tx_shifter.sv
// rtl/serial_tx_shifter.sv - parallel-in serial-out transmitter with framing strobe; SERIAL_TX_PARITY_EN appends even parity
module serial_tx_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input logic                clk,
  input logic                rst_n,
  serial_tx_shifter_if.slave bus
);
  localparam int FW = WIDTH + PAR_BITS;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FW - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sframe_q;
  logic          done_w;
  logic          accept;
  logic          shift_en;
  logic [FW-1:0] frame_word;

  // parity rides in the shift register as the last bit out
`ifdef SERIAL_TX_PARITY_EN
  assign done_w     = (state == ST_PARITY);
  assign frame_word = (MSB_FIRST != 0) ? {bus.load_data, ^bus.load_data}
                                       : {^bus.load_data, bus.load_data};
`else
  assign done_w     = (state == ST_SHIFT) && (cnt == '0);
  assign frame_word = bus.load_data;
`endif

  assign bus.load_ready = (state == ST_IDLE) || done_w;
  assign accept         = bus.load_valid && bus.load_ready;
  assign shift_en       = (state != ST_IDLE) && !accept;
  assign bus.done       = done_w;
  assign bus.sframe     = sframe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sframe_q <= 1'b0;
    end else if (accept) begin
      state    <= ST_SHIFT;
      cnt      <= CNT_LOAD;
      sframe_q <= 1'b1;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (cnt == '0) begin
            state    <= ST_IDLE;
            sframe_q <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
`ifdef SERIAL_TX_PARITY_EN
            if (cnt == CW'(1)) begin
              state <= ST_PARITY;
            end
`endif
          end
        end
        ST_PARITY: begin
          state    <= ST_IDLE;
          sframe_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  piso_shift_reg #(
    .WIDTH     (FW),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .shift      (shift_en),
    .data_in    (frame_word),
    .serial_out (bus.sdata)
  );
endmodule

// File: tb/tb_serial_tx_shifter.sv
// tb/tb_serial_tx_shifter.sv - scoreboard bench for serial_tx_shifter, LSB-first and MSB-first instances
module tb_serial_tx_shifter;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F = 8 + PAR;

  typedef struct packed {
    logic sd;
    logic dn;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   last_wait;
  logic done_at_accept;
  exp_t q0[$];
  exp_t q1[$];

  serial_tx_shifter_if #(.WIDTH(8)) if0 ();
  serial_tx_shifter_if #(.WIDTH(8)) if1 ();

  serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input int which, input logic [7:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.sd = (which == 1) ? w[7-i] : w[i];
      e.dn = (i == 7) && (PAR == 0);
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
    if (PAR == 1) begin
      e.sd = ^w;
      e.dn = 1'b1;
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
  endtask

  // called at a negedge; returns at the negedge of the first frame bit
  task automatic send(input int which, input logic [7:0] w);
    int n;
    logic rdy;
    n = 0;
    if (which == 0) begin if0.load_valid = 1'b1; if0.load_data = w; end
    else            begin if1.load_valid = 1'b1; if1.load_data = w; end
    rdy = (which == 0) ? if0.load_ready : if1.load_ready;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
      rdy = (which == 0) ? if0.load_ready : if1.load_ready;
    end
    last_wait = n;
    done_at_accept = (which == 0) ? if0.done : if1.done;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d actual=not_ready required=ready", which);
    end else begin
      push_frame(which, w);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_valid(input int which);
    if (which == 0) if0.load_valid = 1'b0;
    else            if1.load_valid = 1'b0;
  endtask

  task automatic mon(input int which);
    logic sf, sd, dn;
    exp_t e;
    sf = (which == 0) ? if0.sframe : if1.sframe;
    sd = (which == 0) ? if0.sdata  : if1.sdata;
    dn = (which == 0) ? if0.done   : if1.done;
    if (sf) begin
      if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow dut%0d actual=frame_bit required=none t=%0t", which, $time);
      end else begin
        if (which == 0) e = q0.pop_front();
        else            e = q1.pop_front();
        check_bit($sformatf("dut%0d_sdata", which), sd, e.sd);
        check_bit($sformatf("dut%0d_done", which), dn, e.dn);
      end
    end else begin
      check_bit($sformatf("dut%0d_idle_sdata", which), sd, 1'b0);
      check_bit($sformatf("dut%0d_idle_done", which), dn, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if0.load_valid = 1'b0; if0.load_data = '0;
    if1.load_valid = 1'b0; if1.load_data = '0;
    #12;
    check_bit("rst_sdata0", if0.sdata, 1'b0);
    check_bit("rst_sframe0", if0.sframe, 1'b0);
    check_bit("rst_done0", if0.done, 1'b0);
    check_bit("rst_ready0", if0.load_ready, 1'b1);
    check_bit("rst_sdata1", if1.sdata, 1'b0);
    check_bit("rst_sframe1", if1.sframe, 1'b0);
    check_bit("rst_done1", if1.done, 1'b0);
    check_bit("rst_ready1", if1.load_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single word, LSB first: 1,0,1,0,0,1,0,1
    send(0, 8'hA5);
    release_valid(0);
    repeat (F + 3) @(negedge clk);

    // MSB first: 1,0,0,0,0,0,0,1
    send(1, 8'h81);
    release_valid(1);
    repeat (F + 3) @(negedge clk);

    // back-to-back with valid held high
    send(0, 8'h0F);
    fork
      begin
        send(0, 8'hF0);
        release_valid(0);
      end
      begin
        int run;
        run = 0;
        for (int i = 0; i < 2 * F; i++) begin
          if (if0.sframe) run++;
          @(negedge clk);
        end
        check_int("b2b_sframe_run", run, 2 * F);
        check_bit("b2b_end_sframe", if0.sframe, 1'b0);
      end
    join
    check_int("b2b_accept_wait", last_wait, F - 1);
    check_bit("b2b_accept_in_done", done_at_accept, 1'b1);
    repeat (3) @(negedge clk);

    // busy hold-off: offer 3C at cycle 3 of a frame
    send(0, 8'h5A);
    release_valid(0);
    repeat (2) @(negedge clk);
    check_bit("busy_ready_low", if0.load_ready, 1'b0);
    send(0, 8'h3C);
    release_valid(0);
    check_int("busy_wait_cycles", last_wait, F - 3);
    check_bit("busy_accept_in_done", done_at_accept, 1'b1);
    repeat (F + 3) @(negedge clk);

    // parity cases (frames stay 8 bits without parity)
    send(0, 8'h07);
    release_valid(0);
    repeat (F + 2) @(negedge clk);
    send(1, 8'h03);
    release_valid(1);
    repeat (F + 2) @(negedge clk);

    // reset in cycle 4 of an FF frame
    send(0, 8'hFF);
    release_valid(0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_bit("midrst_sframe", if0.sframe, 1'b0);
    check_bit("midrst_sdata", if0.sdata, 1'b0);
    check_bit("midrst_done", if0.done, 1'b0);
    check_bit("midrst_ready", if0.load_ready, 1'b1);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    check_bit("inrst_done", if0.done, 1'b0);
    #2 rst_n = 1'b1;
    repeat (F + 3) @(negedge clk);

    check_int("sb0_empty", q0.size(), 0);
    check_int("sb1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_tx_shifter.md
# serial_tx_shifter

Parallel-in, serial-out transmitter that takes a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with a framing strobe. It is the sending end of the team's flip-flop-based serial capture path: the capture side samples `sdata` on each rising edge of `clk` while `sframe` is high. It sits between a parallel data producer and the serial link.

## Interface
- `WIDTH`, 8: data word width in bits, legal range 2–32.
- `MSB_FIRST`, 0: 0 sends bit 0 first; 1 sends bit WIDTH-1 first.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  producer has a word on `load_data`.
- `load_ready`  out  1  block accepts a word this cycle.
- `load_data`  in  WIDTH  word to transmit; sampled only on accept.
- `sdata`  out  1  serial data bit, registered.
- `sframe`  out  1  high while `sdata` carries a valid frame bit, registered.
- `done`  out  1  high during the cycle in which the final frame bit is on `sdata`.

## Operation
- **Accept:** a word is accepted on a rising edge when `load_valid && load_ready`. `load_data` is copied into an internal shift register, and the bit counter is loaded with the frame length minus 1.
- **States:**
  - IDLE: `load_ready` = 1, `sframe` = 0, `sdata` = 0.
  - SHIFT: one data bit per cycle.
  - PARITY: only present when parity is compiled in.
- **Transitions:**
  - IDLE → SHIFT on accept.
  - SHIFT → SHIFT while the counter is nonzero.
  - SHIFT → PARITY when the counter reaches 0 and parity is enabled.
  - SHIFT or PARITY → IDLE after the final bit, unless a new word is accepted in that same cycle.
- **Bit order:** with `MSB_FIRST`=0, the register shifts right and `sdata` takes its LSB. With `MSB_FIRST`=1, it shifts left and `sdata` takes its MSB.
- **Counter:** width is clog2(WIDTH+1). It decrements once per transmitted bit and never wraps below 0.
- **`load_ready`:** high in IDLE and during the final-bit cycle (`done`=1). It is low during every other frame cycle. Valid words offered while busy are held off and are not dropped.
- **Back-to-back:** an accept during the final-bit cycle makes bit 0 of the next frame appear in the very next cycle, with no idle gap. `sframe` stays high across the boundary.
- **`done`:** combinational decode of state and counter. It is a single-cycle pulse per frame.
- **`load_valid` rule:** `load_valid` may drop without an accept. The block is indifferent to `load_data` changes while `load_ready` is low.

## Timing
- **Reset values:** `sdata` = 0, `sframe` = 0, `done` = 0, `load_ready` = 1, state = IDLE, shift register = 0, counter = 0.
- **Reset mid-frame:** the frame is aborted immediately and asynchronously. Outputs return to their reset values and no partial-frame `done` is issued.
- **Latency:** the first frame bit is on `sdata` in the cycle after accept, with `sframe` = 1.
- **Frame length:** F = WIDTH cycles, or WIDTH+1 cycles with parity.
- **`done`:** high in cycle F after accept, counting the first bit cycle as cycle 1.
- **Throughput:** one frame every F cycles with continuous `load_valid`.
- **Output stability:** `sdata` and `sframe` change only on rising edges of `clk`, or on reset assertion.

## Configuration
- `SERIAL_TX_PARITY_EN` defined:
  - One extra frame bit is appended after the data bits, in the PARITY state.
  - Its value is the even parity of the accepted word (XOR of all WIDTH bits), captured at accept.
  - `done` and the `load_ready` reopening move to the parity-bit cycle.
- `SERIAL_TX_PARITY_EN` undefined:
  - The PARITY state and parity register do not exist.
  - The frame is exactly WIDTH bits.

## Structure
- **Package `serial_pkg`:**
  - state enum (ST_IDLE, ST_SHIFT, ST_PARITY);
  - counter-width function, clog2(WIDTH+1);
  - `localparam` for the parity frame-extension bit count (0 or 1 depending on the macro).
- **Sub-module `piso_shift_reg`:**
  - parameters WIDTH and MSB_FIRST;
  - inputs `load`, `shift`, data in;
  - output `serial_out`.
- **Top level:** the FSM, counter, parity, and handshake logic stay in the top module.

## Test plan
- **Reset, then single word:** WIDTH=8, MSB_FIRST=0, load 8'hA5.
  - `sdata` over 8 cycles is 1,0,1,0,0,1,0,1 with `sframe`=1.
  - `done` is high only in cycle 8.
  - Then the block returns to IDLE with `sframe`=0.
- **MSB_FIRST=1, load 8'h81:** `sdata` is 1,0,0,0,0,0,0,1.
- **Back-to-back:** `load_valid` held high with words 8'h0F then 8'hF0.
  - The second word is accepted in the `done` cycle.
  - `sframe` stays high for 16 consecutive cycles with no gap.
- **Busy hold-off:** assert `load_valid` with 8'h3C at cycle 3 of a frame.
  - `load_ready` stays 0 until the `done` cycle.
  - 8'h3C is accepted then, and neither word is lost.
- **Reset mid-frame:** deassert `rst_n` at cycle 4 of an 8'hFF frame.
  - `sframe`, `sdata`, and `done` go to 0 immediately, and `load_ready` goes to 1.
  - There is no `done` pulse.
- **With `SERIAL_TX_PARITY_EN`:**
  - 8'h07 gives a 9-bit frame ending in parity bit 1.
  - 8'h03 gives one ending in parity bit 0.
  - `done` is high in cycle 9.
